lsu_mc: RTL and testbench

Multi-cycle, parametrised load/store unit and the successor to the single-cycle LSU. It accepts one request at a time over a valid/ready handshake and returns loads over a one-cycle response pulse. Misaligned data-memory accesses are split into two word transactions by an FSM against a synchronous-read, byte-enabled word memory. Peripherals are parametrised: LED widths, HEX digit count and switch width; switches pass through a 2-flop synchroniser.

---
 rtl/lsu_mc_pkg.sv | 57 +++++
 rtl/lsu_mc_dmem.sv | 27 ++
 rtl/lsu_mc.sv | 197 +++++++++++++++++++
 tb/tb_lsu_mc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_mc_pkg.sv
// Shared constants, FSM encoding and lane/extract helpers for the multi-cycle LSU.
package lsu_mc_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] LEDR_BASE = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE = 32'h1000_1000;
  localparam logic [31:0] HEX_BASE  = 32'h1000_2000;
  localparam logic [31:0] LCD_BASE  = 32'h1000_4000;
  localparam logic [31:0] SW_BASE   = 32'h1001_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_LO,
    S_LD_HI,
    S_ST_HI,
    S_RESP
  } state_e;

  // {hi_mask, lo_mask}: size mask shifted by the byte offset; overflow spills into hi.
  function automatic logic [7:0] lane_masks(input logic [2:0] func3, input logic [1:0] off);
    logic [7:0] base;
    case (func3)
      F3_B, F3_BU: base = 8'b0000_0001;
      F3_H, F3_HU: base = 8'b0000_0011;
      default:     base = 8'b0000_1111;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] func3, input logic [31:0] lo_word,
                                               input logic [31:0] hi_word, input logic [1:0] off);
    logic [31:0] sel;
    sel = 32'({hi_word, lo_word} >> {off, 3'b000});
    case (func3)
      F3_B:    return {{24{sel[7]}}, sel[7:0]};
      F3_H:    return {{16{sel[15]}}, sel[15:0]};
      F3_BU:   return {24'b0, sel[7:0]};
      F3_HU:   return {16'b0, sel[15:0]};
      default: return sel;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word, input logic [31:0] new_word,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_word;
    for (int j = 0; j < 4; j++)
      if (be[j]) r[8*j +: 8] = new_word[8*j +: 8];
    return r;
  endfunction

endpackage

// File: rtl/lsu_mc_dmem.sv
// Word-wide data memory: byte-enabled write port and one-cycle synchronous read.
module lsu_mc_dmem
  import lsu_mc_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++)
      if (be[j]) mem_q[addr][8*j +: 8] <= wdata[8*j +: 8];
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: splits misaligned dmem accesses into two word
// transactions and serves a small bank of memory-mapped peripherals.
module lsu_mc
  import lsu_mc_pkg::*;
#(
  parameter int DMEM_DEPTH = 16384,
  parameter int NUM_HEX    = 8,
  parameter int LEDR_W     = 32,
  parameter int LEDG_W     = 32,
  parameter int SW_W       = 32,
  parameter int LCD_W      = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [31:0]          i_lsu_addr,
  input  logic [31:0]          i_st_data,
  input  logic                 i_lsu_wren,
  input  logic [2:0]           i_func3,
  output logic                 o_rsp_valid,
  output logic [31:0]          o_ld_data,
  input  logic [SW_W-1:0]      i_io_sw,
  output logic [LEDR_W-1:0]    o_io_ledr,
  output logic [LEDG_W-1:0]    o_io_ledg,
  output logic [NUM_HEX*7-1:0] o_io_hex,
  output logic [LCD_W-1:0]     o_io_lcd
);

  localparam int AW        = $clog2(DMEM_DEPTH);
  localparam int HEX_WORDS = NUM_HEX / 4;

  state_e               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [1:0]           off_q, off_d;
  logic [2:0]           func3_q, func3_d;
  logic [31:0]          st_data_q, st_data_d;
  logic [31:0]          lo_buf_q, lo_buf_d;
  logic [31:0]          ld_data_q, ld_data_d;
  logic [LEDR_W-1:0]    ledr_q, ledr_d;
  logic [LEDG_W-1:0]    ledg_q, ledg_d;
  logic [LCD_W-1:0]     lcd_q, lcd_d;
  logic [NUM_HEX*7-1:0] hex_q, hex_d;
  logic [SW_W-1:0]      sw_meta_q, sw_sync_q;

  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_re;

  logic [7:0]  req_masks, q_masks;
  logic [31:0] req_st_lo, q_st_hi, io_rdata;
  logic [29:0] hex_word;

  lsu_mc_dmem #(.DEPTH(DMEM_DEPTH), .AW(AW)) u_dmem (
    .clk   (i_clk),
    .addr  (mem_addr),
    .be    (mem_be),
    .wdata (mem_wdata),
    .re    (mem_re),
    .rdata (mem_rdata)
  );

  assign req_masks = lane_masks(i_func3, i_lsu_addr[1:0]);
  assign req_st_lo = i_st_data << {i_lsu_addr[1:0], 3'b000};
  assign q_masks   = lane_masks(func3_q, off_q);
  assign q_st_hi   = st_data_q >> (6'd32 - {1'b0, off_q, 3'b000});
  assign hex_word  = i_lsu_addr[31:2] - HEX_BASE[31:2];

  // IO read mux; only the addressed word is visible, so crossing lanes read as zero.
  always_comb begin
    io_rdata = '0;
    if (i_lsu_addr[31:2] == LEDR_BASE[31:2]) io_rdata = 32'(ledr_q);
    if (i_lsu_addr[31:2] == LEDG_BASE[31:2]) io_rdata = 32'(ledg_q);
    if (i_lsu_addr[31:2] == LCD_BASE[31:2])  io_rdata = 32'(lcd_q);
    if (i_lsu_addr[31:2] == SW_BASE[31:2])   io_rdata = 32'(sw_sync_q);
    for (int k = 0; k < HEX_WORDS; k++)
      if (hex_word == 30'(k))
        for (int j = 0; j < 4; j++)
          io_rdata[8*j +: 8] = {1'b0, hex_q[7*(4*k+j) +: 7]};
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    off_d     = off_q;
    func3_d   = func3_q;
    st_data_d = st_data_q;
    lo_buf_d  = lo_buf_q;
    ld_data_d = ld_data_q;
    ledr_d    = ledr_q;
    ledg_d    = ledg_q;
    lcd_d     = lcd_q;
    hex_d     = hex_q;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    case (state_q)
      S_IDLE: if (i_req_valid) begin
        idx_d     = i_lsu_addr[AW+1:2];
        off_d     = i_lsu_addr[1:0];
        func3_d   = i_func3;
        st_data_d = i_st_data;
        if (i_lsu_addr[28]) begin
          state_d = S_RESP;
          if (i_lsu_wren) begin
            if (i_lsu_addr[31:2] == LEDR_BASE[31:2])
              ledr_d = LEDR_W'(merge_lanes(32'(ledr_q), req_st_lo, req_masks[3:0]));
            if (i_lsu_addr[31:2] == LEDG_BASE[31:2])
              ledg_d = LEDG_W'(merge_lanes(32'(ledg_q), req_st_lo, req_masks[3:0]));
            if (i_lsu_addr[31:2] == LCD_BASE[31:2])
              lcd_d = LCD_W'(merge_lanes(32'(lcd_q), req_st_lo, req_masks[3:0]));
            for (int d = 0; d < NUM_HEX; d++)
              if (hex_word == 30'(d / 4) && req_masks[d % 4])
                hex_d[7*d +: 7] = req_st_lo[8*(d % 4) +: 7];
          end else begin
            ld_data_d = load_extract(i_func3, io_rdata, 32'b0, i_lsu_addr[1:0]);
          end
        end else begin
          mem_addr = i_lsu_addr[AW+1:2];
          if (i_lsu_wren) begin
            mem_be    = req_masks[3:0];
            mem_wdata = req_st_lo;
            state_d   = (|req_masks[7:4]) ? S_ST_HI : S_RESP;
          end else begin
            mem_re  = 1'b1;
            state_d = S_LD_LO;
          end
        end
      end
      S_ST_HI: begin
        mem_addr  = idx_q + AW'(1);
        mem_be    = q_masks[7:4];
        mem_wdata = q_st_hi;
        state_d   = S_RESP;
      end
      S_LD_LO: begin
        lo_buf_d = mem_rdata;
        if (|q_masks[7:4]) begin
          mem_addr = idx_q + AW'(1);
          mem_re   = 1'b1;
          state_d  = S_LD_HI;
        end else begin
          ld_data_d = load_extract(func3_q, mem_rdata, 32'b0, off_q);
          state_d   = S_RESP;
        end
      end
      S_LD_HI: begin
        ld_data_d = load_extract(func3_q, lo_buf_q, mem_rdata, off_q);
        state_d   = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      off_q     <= '0;
      func3_q   <= '0;
      st_data_q <= '0;
      lo_buf_q  <= '0;
      ld_data_q <= '0;
      ledr_q    <= '0;
      ledg_q    <= '0;
      lcd_q     <= '0;
      hex_q     <= '1;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      off_q     <= off_d;
      func3_q   <= func3_d;
      st_data_q <= st_data_d;
      lo_buf_q  <= lo_buf_d;
      ld_data_q <= ld_data_d;
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      lcd_q     <= lcd_d;
      hex_q     <= hex_d;
      sw_meta_q <= i_io_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_ld_data   = ld_data_q;
  assign o_io_ledr   = ledr_q;
  assign o_io_ledg   = ledg_q;
  assign o_io_lcd    = lcd_q;
  assign o_io_hex    = hex_q;

endmodule

// File: tb/tb_lsu_mc.sv
// Directed bench for lsu_mc: hand-computed load data and response latencies.
module tb_lsu_mc;

  localparam int DEPTH = 16384;
  localparam int NHEX  = 8;

  logic            i_clk, i_reset, i_req_valid, o_req_ready, i_lsu_wren, o_rsp_valid;
  logic [31:0]     i_lsu_addr, i_st_data, o_ld_data, i_io_sw;
  logic [31:0]     o_io_ledr, o_io_ledg, o_io_lcd;
  logic [2:0]      i_func3;
  logic [NHEX*7-1:0] o_io_hex;
  logic [55:0]     exp_hex;
  int              compares = 0;
  int              mismatches = 0;

  lsu_mc #(
    .DMEM_DEPTH(DEPTH), .NUM_HEX(NHEX), .LEDR_W(32), .LEDG_W(32), .SW_W(32), .LCD_W(32)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_lsu_addr  (i_lsu_addr),
    .i_st_data   (i_st_data),
    .i_lsu_wren  (i_lsu_wren),
    .i_func3     (i_func3),
    .o_rsp_valid (o_rsp_valid),
    .o_ld_data   (o_ld_data),
    .i_io_sw     (i_io_sw),
    .o_io_ledr   (o_io_ledr),
    .o_io_ledg   (o_io_ledg),
    .o_io_hex    (o_io_hex),
    .o_io_lcd    (o_io_lcd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compares++;
    if (observed !== expected) begin
      mismatches++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issues one request and waits (bounded) for the response pulse; lat = -1 on timeout.
  task automatic applyStimulus(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] data, output logic [31:0] rdata, output int lat);
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_lsu_wren  = wren;
    i_func3     = f3;
    i_lsu_addr  = addr;
    i_st_data   = data;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    lat   = -1;
    rdata = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge i_clk);
      if (o_rsp_valid) begin
        lat   = k;
        rdata = o_ld_data;
        break;
      end
    end
  endtask

  task automatic doOp(input string tag, input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] data, input int expLat, input logic [31:0] expData);
    logic [31:0] r;
    int lat;
    applyStimulus(wren, f3, addr, data, r, lat);
    checkOutput({tag, "_lat"}, 64'(lat), 64'(expLat));
    if (!wren) checkOutput({tag, "_data"}, {32'b0, r}, {32'b0, expData});
  endtask

  initial begin
    i_reset     = 1'b1;
    i_req_valid = 1'b0;
    i_lsu_wren  = 1'b0;
    i_func3     = 3'b010;
    i_lsu_addr  = '0;
    i_st_data   = '0;
    i_io_sw     = 32'hCAFE_1234;
    exp_hex     = {8{7'h7F}};
    #1 i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);

    $display("[TB] reset state");
    checkOutput("rst_ready", {63'b0, o_req_ready}, 64'd1);
    checkOutput("rst_rsp", {63'b0, o_rsp_valid}, 64'd0);
    checkOutput("rst_ld_data", {32'b0, o_ld_data}, 64'd0);
    checkOutput("rst_ledr", {32'b0, o_io_ledr}, 64'd0);
    checkOutput("rst_ledg", {32'b0, o_io_ledg}, 64'd0);
    checkOutput("rst_lcd", {32'b0, o_io_lcd}, 64'd0);
    checkOutput("rst_hex", {8'b0, o_io_hex}, {8'b0, exp_hex});
    doOp("rd_ledr", 1'b0, 3'b010, 32'h1000_0000, 0, 1, 32'h0);
    doOp("rd_ledg", 1'b0, 3'b010, 32'h1000_1000, 0, 1, 32'h0);
    doOp("rd_lcd", 1'b0, 3'b010, 32'h1000_4000, 0, 1, 32'h0);
    doOp("rd_hex0", 1'b0, 3'b010, 32'h1000_2000, 0, 1, 32'h7F7F_7F7F);

    $display("[TB] aligned dmem");
    doOp("sw_0", 1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF, 1, 0);
    doOp("lw_0", 1'b0, 3'b010, 32'h0, 0, 2, 32'hDEAD_BEEF);
    doOp("sb_3", 1'b1, 3'b000, 32'h3, 32'h0000_0080, 1, 0);
    doOp("lb_3", 1'b0, 3'b000, 32'h3, 0, 2, 32'hFFFF_FF80);
    doOp("lbu_3", 1'b0, 3'b100, 32'h3, 0, 2, 32'h0000_0080);
    doOp("lw_0b", 1'b0, 3'b010, 32'h0, 0, 2, 32'h80AD_BEEF);

    $display("[TB] misaligned dmem");
    doOp("sw_6", 1'b1, 3'b010, 32'h6, 32'h1122_3344, 2, 0);
    doOp("lw_6", 1'b0, 3'b010, 32'h6, 0, 3, 32'h1122_3344);
    doOp("lh_7", 1'b0, 3'b001, 32'h7, 0, 3, 32'h0000_2233);
    doOp("lb_6", 1'b0, 3'b000, 32'h6, 0, 2, 32'h0000_0044);
    doOp("sh_b", 1'b1, 3'b001, 32'hB, 32'h0000_8001, 2, 0);
    doOp("lh_b", 1'b0, 3'b001, 32'hB, 0, 3, 32'hFFFF_8001);
    doOp("lhu_b", 1'b0, 3'b101, 32'hB, 0, 3, 32'h0000_8001);

    $display("[TB] wrap and odd func3");
    doOp("sh_wrap", 1'b1, 3'b001, 32'(4*DEPTH-1), 32'h0000_ABCD, 2, 0);
    doOp("lw_0_wrap", 1'b0, 3'b010, 32'h0, 0, 2, 32'h80AD_BEAB);
    doOp("lb_top", 1'b0, 3'b000, 32'(4*DEPTH-1), 0, 2, 32'hFFFF_FFCD);
    doOp("lh_wrap", 1'b0, 3'b001, 32'(4*DEPTH-1), 0, 3, 32'hFFFF_ABCD);
    doOp("f3_011", 1'b0, 3'b011, 32'h0, 0, 2, 32'h80AD_BEAB);

    $display("[TB] peripherals");
    doOp("sw_ledr", 1'b1, 3'b010, 32'h1000_0000, 32'h1234_5678, 1, 0);
    checkOutput("ledr_out", {32'b0, o_io_ledr}, 64'h1234_5678);
    doOp("lw_ledr", 1'b0, 3'b010, 32'h1000_0000, 0, 1, 32'h1234_5678);
    doOp("sh_ledr3", 1'b1, 3'b001, 32'h1000_0003, 32'h0000_BEEF, 1, 0);
    checkOutput("ledr_cross", {32'b0, o_io_ledr}, 64'hEF34_5678);
    doOp("lb_ledr3", 1'b0, 3'b000, 32'h1000_0003, 0, 1, 32'hFFFF_FFEF);
    doOp("sw_ledg", 1'b1, 3'b010, 32'h1000_1000, 32'hA5A5_A5A5, 1, 0);
    checkOutput("ledg_out", {32'b0, o_io_ledg}, 64'hA5A5_A5A5);
    doOp("sw_lcd", 1'b1, 3'b010, 32'h1000_4000, 32'h0BAD_F00D, 1, 0);
    checkOutput("lcd_out", {32'b0, o_io_lcd}, 64'h0BAD_F00D);
    doOp("lw_sw", 1'b0, 3'b010, 32'h1001_0000, 0, 1, 32'hCAFE_1234);
    doOp("lw_unmapped", 1'b0, 3'b010, 32'h1000_3000, 0, 1, 32'h0);
    doOp("sb_hex5", 1'b1, 3'b000, 32'h1000_2005, 32'h0000_003F, 1, 0);
    exp_hex[41:35] = 7'h3F;
    checkOutput("hex_out", {8'b0, o_io_hex}, {8'b0, exp_hex});
    doOp("lhu_hex1", 1'b0, 3'b101, 32'h1000_2004, 0, 1, 32'h0000_3F7F);
    doOp("sw_hex2", 1'b1, 3'b010, 32'h1000_2008, 32'h0, 1, 0);
    checkOutput("hex_unchanged", {8'b0, o_io_hex}, {8'b0, exp_hex});

    $display("[TB] reset during LD_HI");
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_lsu_wren  = 1'b0;
    i_func3     = 3'b010;
    i_lsu_addr  = 32'h6;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    @(posedge i_clk);
    #1 i_reset = 1'b0;
    #1;
    checkOutput("abort_rsp", {63'b0, o_rsp_valid}, 64'd0);
    checkOutput("abort_ready", {63'b0, o_req_ready}, 64'd1);
    repeat (2) begin
      @(negedge i_clk);
      checkOutput("abort_no_rsp", {63'b0, o_rsp_valid}, 64'd0);
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    checkOutput("post_rst_ready", {63'b0, o_req_ready}, 64'd1);
    checkOutput("post_rst_rsp", {63'b0, o_rsp_valid}, 64'd0);
    checkOutput("post_rst_ledr", {32'b0, o_io_ledr}, 64'd0);
    exp_hex = {8{7'h7F}};
    checkOutput("post_rst_hex", {8'b0, o_io_hex}, {8'b0, exp_hex});
    doOp("lw_6_after", 1'b0, 3'b010, 32'h6, 0, 3, 32'h1122_3344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
